// File: rtl/flush_ctrl.sv
// Sequential pipeline flush controller: queues fetch-time predictions and checks them as
// control instructions resolve. Define FLUSH_CTRL_JAL_PREDICT_EN to make JAL compare-then-flush.
//
// state     | meaning
// ST_WARMUP | post-reset warm-up, resolves pop but never trigger
// ST_RUN    | normal operation, mispredicts trigger a flush
// ST_FLUSH  | flush window, resolves and pushes are ignored
module flush_ctrl #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int WARMUP       = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [XLEN-1:0]          pred_pc,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic [4:0]               res_opcode,
  input  logic [XLEN-1:0]          res_next_pc,
  output logic                     flush,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (WARMUP > FLUSH_CYCLES) ? WARMUP : FLUSH_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [4:0]    OP_JAL    = 5'b11011;
  localparam logic [4:0]    OP_JALR   = 5'b11001;
  localparam logic [4:0]    OP_BRANCH = 5'b11000;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [TW-1:0] T_WARM    = TW'(WARMUP);
  localparam logic [TW-1:0] T_FLUSH   = TW'(FLUSH_CYCLES);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_FLUSH} state_t;
  localparam state_t ST_RESET = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic              rv_q, rv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [XLEN-1:0]   head;
  logic              active, is_ctrl, do_res, empty, full;
  logic              pop, push_req, push, mis, jal_mis, trig, wr_en;

  assign head     = mem_q[rd_ptr_q];
  assign active   = (state_q != ST_FLUSH);
  assign is_ctrl  = (res_opcode == OP_JAL) || (res_opcode == OP_JALR) || (res_opcode == OP_BRANCH);
  assign do_res   = res_valid && is_ctrl && active;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign pop      = do_res && !empty;
  assign push_req = pred_valid && active;
  assign push     = push_req && (!full || pop);

`ifdef FLUSH_CTRL_JAL_PREDICT_EN
  assign jal_mis = (head != res_next_pc);
`else
  assign jal_mis = 1'b1;
`endif

  always_comb begin
    mis = 1'b0;
    if (empty) begin
      mis = 1'b1;
    end else begin
      case (res_opcode)
        OP_JALR: mis = 1'b1;
        OP_JAL:  mis = jal_mis;
        default: mis = (head != res_next_pc);
      endcase
    end
  end

  // Warm-up shows up here: only ST_RUN may trigger.
  assign trig  = do_res && mis && (state_q == ST_RUN);
  assign wr_en = push && !trig;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rpc_d    = rpc_q;
    rv_d     = trig;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (do_res && empty) unf_d = 1'b1;
    if (push_req && full && !pop) ovf_d = 1'b1;

    if (trig) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rpc_d    = res_next_pc;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    case (state_q)
      ST_WARMUP: begin
        if (tmr_q <= T_ONE) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - T_ONE;
        end
      end
      ST_RUN: begin
        if (trig) begin
          state_d = ST_FLUSH;
          tmr_d   = T_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (tmr_q <= T_ONE) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - T_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      tmr_q    <= T_WARM;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rpc_q    <= '0;
      rv_q     <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rpc_q    <= rpc_d;
      rv_q     <= rv_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pred_pc;
  end

  assign pred_ready     = (count_q != CNT_FULL);
  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign q_count        = count_q;
  assign mispredict_cnt = cnt_q;
  assign err_overflow   = ovf_q;
  assign err_underflow  = unf_q;

endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
Sequential, parametrised pipeline flush controller for the RV32 core; successor to the combinational flush logic.
- Queues predicted PCs issued at fetch and pops one per resolved control instruction in execute.
- Compares each resolved next-PC with the queued prediction.
- Drives a registered, multi-cycle flush window plus a one-cycle redirect.
- Suppresses flushes during a post-reset warm-up period.

Parameters:
- XLEN, 32, PC width.
- DEPTH, 4, prediction queue entries; power of 2, minimum 2.
- FLUSH_CYCLES, 2, consecutive cycles flush stays high per event; minimum 1.
- WARMUP, 2, cycles after reset release during which flush is suppressed.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pred_valid  in  1  push pred_pc into queue.
- pred_pc  in  XLEN  predicted next PC for a fetched control instruction.
- pred_ready  out  1  queue not full.
- res_valid  in  1  an instruction resolves in execute this cycle.
- res_opcode  in  5  instr[6:2] of the resolving instruction.
- res_next_pc  in  XLEN  architecturally correct next PC.
- flush  out  1  kill younger pipeline stages.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  XLEN  corrected PC.
- q_count  out  $clog2(DEPTH)+1  queue occupancy.
- mispredict_cnt  out  CNT_W  saturating count of flush events.
- err_overflow  out  1  sticky: push while full.
- err_underflow  out  1  sticky: control resolve with empty queue.

Behaviour:
Reset, while rst_n is low, all outputs are forced immediately:
- flush=0, redirect_valid=0, redirect_pc=0
- queue empty, q_count=0, pred_ready=1
- mispredict_cnt=0, both error flags 0
- warm-up counter loaded with WARMUP; flush window counter 0

Warm-up:
- Counter decrements each cycle after reset release until 0.
- While it is non-zero, no flush event triggers: no flush, no redirect, no counter increment, no queue clear.
- Queue push and pop still operate normally during warm-up.

Opcode classes:
- JAL = 11011, JALR = 11001, BRANCH = 11000.
- Any other opcode: no pop, no flush.

Resolve, evaluated when res_valid=1 and the flush window is inactive:
- JAL or JALR: pop head; trigger unconditionally (unless JAL_PREDICT_EN, see Optional Feature).
- BRANCH: pop head; trigger if head != res_next_pc (full XLEN compare).
- Control opcode with empty queue: set err_underflow; trigger (target unknown).

Trigger, registered with 1-cycle latency:
- Next cycle: flush=1 for FLUSH_CYCLES cycles.
- redirect_valid=1 in the first of those cycles only.
- redirect_pc=res_next_pc, held until the next trigger.
- mispredict_cnt increments by 1 and saturates at all-ones.
- On the trigger cycle the queue is cleared: all entries are wrong-path. The clear overrides any same-cycle push.

Flush window:
- res_valid is ignored (wrong-path); no pop.
- pred_valid is ignored; no push.
- Window expiry returns to normal operation the following cycle.
- A trigger cannot re-arm the window early; back-to-back events are separated by at least FLUSH_CYCLES.

Queue:
- FIFO with circular pointers wrapping modulo DEPTH.
- Simultaneous push and pop without trigger: both occur; q_count unchanged.
- Push while full (pred_ready=0) and no same-cycle pop: entry dropped, err_overflow set.
- Push while full with a same-cycle pop: accepted.
- pred_ready is combinational from q_count only.

Error flags: cleared only by reset.

Reset mid-window: flush deasserts immediately; queue empties; warm-up restarts.

Optional Feature:
Macro FLUSH_CTRL_JAL_PREDICT_EN.
- Defined: JAL is handled like BRANCH (pop, compare with res_next_pc, trigger only on mismatch). JALR still triggers unconditionally.
- Undefined: JAL always triggers, as described above.

Test Plan:
1. Reset with WARMUP=2. Push 0x100; resolve BRANCH with res_next_pc=0x200 in the first cycle after reset release -> flush stays 0; queue pops; mispredict_cnt=0.
2. After warm-up, push 0x40; resolve BRANCH with res_next_pc=0x40 -> no flush; q_count goes 1 then 0.
3. Push 0x40 and 0x44; resolve BRANCH with 0x80 -> next cycle flush=1 for 2 cycles, redirect_valid=1 for 1 cycle, redirect_pc=0x80, q_count=0, mispredict_cnt=1; a pred_valid during the window is not queued.
4. Resolve JALR with the queue empty -> err_underflow=1, flush for 2 cycles. Repeat as JAL with queue head=0x300 and res_next_pc=0x300: flush only when FLUSH_CTRL_JAL_PREDICT_EN is undefined.
5. Push 5 entries with DEPTH=4 -> pred_ready=0 after 4, err_overflow=1, q_count=4. Then push and pop in the same cycle while full -> accepted, q_count stays 4, FIFO order preserved across pointer wrap.
6. Drop rst_n mid-window -> flush=0 immediately; after release, warm-up suppresses a mismatching BRANCH for 2 cycles. Force 2^CNT_W+1 mismatches -> mispredict_cnt holds at 0xFFFF.
